regfile_4r1w: RTL and testbench

- 16-entry × 8-bit general-purpose register file for the 8-bit FMAT datapath.
- Four independent combinational read ports and one synchronous write port.
- Holds a 1-bit overflow condition register alongside the data registers.
- Sits between instruction decode (read/write addresses) and the ALU/writeback stage, which supplies write data and the overflow flag.

---
 rtl/regfile_4r1w.sv | 69 ++++++
 tb/tb_regfile_4r1w.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_4r1w.sv
// 16 x 8 general-purpose register file with four combinational read ports,
// one synchronous write port and a 1-bit overflow condition register.
// The overflow register is captured alongside every data write.
module regfile_4r1w #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] regRead1_i,
   input  logic [ADDR_WIDTH-1:0] regRead2_i,
   input  logic [ADDR_WIDTH-1:0] regRead3_i,
   input  logic [ADDR_WIDTH-1:0] regRead4_i,
   input  logic                  writeEnable_i,
   input  logic [ADDR_WIDTH-1:0] regWrite_i,
   input  logic [DATA_WIDTH-1:0] dataWrite_i,
   input  logic                  ovrflw_i,
   output logic [DATA_WIDTH-1:0] dataRead1_o,
   output logic [DATA_WIDTH-1:0] dataRead2_o,
   output logic [DATA_WIDTH-1:0] dataRead3_o,
   output logic [DATA_WIDTH-1:0] dataRead4_o,
   output logic                  ovrflw_o
);

   localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NumRegs];
   logic [DATA_WIDTH-1:0] regs_d [NumRegs];
   logic                  ovrflw_q;
   logic                  ovrflw_d;

   // Next-state: only the addressed entry changes, and only while writeEnable_i is high,
   // so X on the write address/data with the strobe low cannot disturb stored state.
   always_comb begin
      ovrflw_d = ovrflw_q;
      for (int i = 0; i < NumRegs; i++) begin
         regs_d[i] = regs_q[i];
         if (writeEnable_i && (regWrite_i == ADDR_WIDTH'(i))) begin
            regs_d[i] = dataWrite_i;
         end
      end
      if (writeEnable_i) begin
         ovrflw_d = ovrflw_i;
      end
   end

   // State update: synchronous reset clears everything and wins over a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
         ovrflw_q <= 1'b0;
      end else begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= regs_d[i];
         end
         ovrflw_q <= ovrflw_d;
      end
   end

   // Reads come straight from the flops: no bypass, a same-address write shows after the edge.
   assign dataRead1_o = regs_q[regRead1_i];
   assign dataRead2_o = regs_q[regRead2_i];
   assign dataRead3_o = regs_q[regRead3_i];
   assign dataRead4_o = regs_q[regRead4_i];
   assign ovrflw_o    = ovrflw_q;

endmodule

// File: tb/tb_regfile_4r1w.sv
// Directed self-checking bench for regfile_4r1w.
module tb_regfile_4r1w;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [3:0] regRead1_i, regRead2_i, regRead3_i, regRead4_i;
   logic       writeEnable_i;
   logic [3:0] regWrite_i;
   logic [7:0] dataWrite_i;
   logic       ovrflw_i;
   logic [7:0] dataRead1_o, dataRead2_o, dataRead3_o, dataRead4_o;
   logic       ovrflw_o;

   int n_checks = 0;
   int n_fails  = 0;

   regfile_4r1w #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(4)
   ) dut (
      .clk          (clk),
      .rst_i        (rst_i),
      .regRead1_i   (regRead1_i),
      .regRead2_i   (regRead2_i),
      .regRead3_i   (regRead3_i),
      .regRead4_i   (regRead4_i),
      .writeEnable_i(writeEnable_i),
      .regWrite_i   (regWrite_i),
      .dataWrite_i  (dataWrite_i),
      .ovrflw_i     (ovrflw_i),
      .dataRead1_o  (dataRead1_o),
      .dataRead2_o  (dataRead2_o),
      .dataRead3_o  (dataRead3_o),
      .dataRead4_o  (dataRead4_o),
      .ovrflw_o     (ovrflw_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; inputs may then be changed safely.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic ov);
      writeEnable_i = 1'b1;
      regWrite_i    = a;
      dataWrite_i   = d;
      ovrflw_i      = ov;
      tick();
      writeEnable_i = 1'b0;
   endtask

   task automatic rd4(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                      input logic [3:0] a4);
      regRead1_i = a1;
      regRead2_i = a2;
      regRead3_i = a3;
      regRead4_i = a4;
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      for (int a = 0; a < 16; a++) begin
         rd4(4'(a), 4'(a), 4'(a), 4'(a));
         check($sformatf("%s_p1_r%0d", tag, a), dataRead1_o, 8'h00);
         check($sformatf("%s_p2_r%0d", tag, a), dataRead2_o, 8'h00);
         check($sformatf("%s_p3_r%0d", tag, a), dataRead3_o, 8'h00);
         check($sformatf("%s_p4_r%0d", tag, a), dataRead4_o, 8'h00);
      end
      check({tag, "_ovrflw"}, {7'd0, ovrflw_o}, 8'h00);
   endtask

   initial begin
      logic [3:0] ad [4];
      rst_i         = 1'b1;
      writeEnable_i = 1'b0;
      regWrite_i    = '0;
      dataWrite_i   = '0;
      ovrflw_i      = 1'b0;
      rd4(4'd0, 4'd0, 4'd0, 4'd0);
      tick();
      rst_i = 1'b0;

      // Arbitrary writes, then reset clears everything.
      wr(4'd0, 8'h5A, 1'b1);
      wr(4'd7, 8'hC3, 1'b1);
      wr(4'd15, 8'h99, 1'b1);
      rd4(4'd7, 4'd15, 4'd0, 4'd7);
      check("pre_rst_r7", dataRead1_o, 8'hC3);
      check("pre_rst_ovrflw", {7'd0, ovrflw_o}, 8'h01);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_all_zero("rst");

      // Basic write/read with overflow capture.
      wr(4'd1, 8'h01, 1'b0);
      check("ov_after_r1", {7'd0, ovrflw_o}, 8'h00);
      wr(4'd2, 8'h02, 1'b1);
      check("ov_after_r2", {7'd0, ovrflw_o}, 8'h01);
      wr(4'd4, 8'h03, 1'b1);
      check("ov_after_r4", {7'd0, ovrflw_o}, 8'h01);
      rd4(4'd1, 4'd2, 4'd4, 4'd0);
      check("basic_p1", dataRead1_o, 8'h01);
      check("basic_p2", dataRead2_o, 8'h02);
      check("basic_p3", dataRead3_o, 8'h03);
      check("basic_p4", dataRead4_o, 8'h00);

      // Write disable: strobe low, overflow input toggling.
      writeEnable_i = 1'b0;
      regWrite_i    = 4'd5;
      dataWrite_i   = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         ovrflw_i = k[0];
         tick();
      end
      rd4(4'd5, 4'd5, 4'd1, 4'd2);
      check("wd_r5", dataRead1_o, 8'h00);
      check("wd_r1", dataRead3_o, 8'h01);
      check("wd_ovrflw", {7'd0, ovrflw_o}, 8'h01);

      // Back-to-back writes with the strobe held high.
      writeEnable_i = 1'b1;
      ovrflw_i      = 1'b0;
      for (int k = 4; k < 8; k++) begin
         regWrite_i  = 4'(k);
         dataWrite_i = 8'(k);
         tick();
      end
      writeEnable_i = 1'b0;
      rd4(4'd4, 4'd5, 4'd6, 4'd7);
      check("b2b_r4", dataRead1_o, 8'h04);
      check("b2b_r5", dataRead2_o, 8'h05);
      check("b2b_r6", dataRead3_o, 8'h06);
      check("b2b_r7", dataRead4_o, 8'h07);
      check("b2b_ovrflw", {7'd0, ovrflw_o}, 8'h00);

      // Same-address timing: no bypass.
      wr(4'd3, 8'h3C, 1'b0);
      rd4(4'd3, 4'd0, 4'd0, 4'd0);
      writeEnable_i = 1'b1;
      regWrite_i    = 4'd3;
      dataWrite_i   = 8'hA5;
      ovrflw_i      = 1'b1;
      #1;
      check("same_before", dataRead1_o, 8'h3C);
      tick();
      writeEnable_i = 1'b0;
      check("same_after", dataRead1_o, 8'hA5);
      rd4(4'd3, 4'd3, 4'd3, 4'd3);
      check("same_p1", dataRead1_o, 8'hA5);
      check("same_p2", dataRead2_o, 8'hA5);
      check("same_p3", dataRead3_o, 8'hA5);
      check("same_p4", dataRead4_o, 8'hA5);
      check("same_ovrflw", {7'd0, ovrflw_o}, 8'h01);

      // Full sweep: reg[i] = i*17, read back with rotating port assignments.
      for (int i = 0; i < 16; i++) begin
         wr(4'(i), 8'(i * 17), 1'b0);
      end
      for (int rot = 0; rot < 4; rot++) begin
         for (int a = 0; a < 16; a++) begin
            for (int p = 0; p < 4; p++) begin
               ad[p] = 4'((a + p * 4 + rot) % 16);
            end
            rd4(ad[0], ad[1], ad[2], ad[3]);
            check($sformatf("sweep_p1_r%0d", ad[0]), dataRead1_o, 8'(ad[0] * 17));
            check($sformatf("sweep_p2_r%0d", ad[1]), dataRead2_o, 8'(ad[1] * 17));
            check($sformatf("sweep_p3_r%0d", ad[2]), dataRead3_o, 8'(ad[2] * 17));
            check($sformatf("sweep_p4_r%0d", ad[3]), dataRead4_o, 8'(ad[3] * 17));
         end
      end

      // Reset together with a write: reset wins, nothing is written.
      rst_i         = 1'b1;
      writeEnable_i = 1'b1;
      regWrite_i    = 4'd9;
      dataWrite_i   = 8'h77;
      ovrflw_i      = 1'b1;
      tick();
      rst_i         = 1'b0;
      writeEnable_i = 1'b0;
      check_all_zero("rst_we");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Absolute time bound so the run cannot hang.
   initial begin
      #200000;
      n_fails++;
      $display("FAIL timeout: observed no completion expected completion");
      $fatal(1, "timeout");
   end

endmodule
